// File: rtl/axi4l_regfile.sv
// axi4l_regfile: parametrised AXI4-Lite slave register file with NUM_REGS registers of DATA_W bits
// Ports: ACLK/ARESETN (sync, active-low); AXI4-Lite AW/W/B/AR/R channels;
//   reg_q = flattened register contents (reg i at [i*DATA_W +: DATA_W]); reg_wr = one-cycle write pulse per register.
// Option: define AXI4L_REGFILE_STRB_EN to honour WSTRB; otherwise every in-range commit writes the full word.
module axi4l_regfile #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);
  localparam int SW  = DATA_W / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [SW-1:0]       w_strb_q, w_strb_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_m;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   widx, ridx;
  logic                win, rin, commit, ar_hs;
  assign widx    = aw_addr_q >> OFF;
  assign ridx    = ARADDR >> OFF;
  assign win     = widx < ADDR_W'(NUM_REGS);
  assign rin     = ridx < ADDR_W'(NUM_REGS);
  assign commit  = aw_full_q && w_full_q && !bvalid_q;
  assign ar_hs   = ARVALID && !rvalid_q;
  assign AWREADY = !aw_full_q;
  assign WREADY  = !w_full_q;
  assign ARREADY = !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign reg_wr  = reg_wr_q;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
  end
`ifndef AXI4L_REGFILE_STRB_EN
  logic unused_strb;
  assign unused_strb = ^w_strb_q;
`endif
  always_comb begin
    regs_d    = regs_q;
    reg_wr_d  = '0;
    wdata_m   = w_data_q;
`ifdef AXI4L_REGFILE_STRB_EN
    for (int k = 0; k < SW; k++)
      wdata_m[k*8 +: 8] = w_strb_q[k] ? w_data_q[k*8 +: 8] : regs_q[widx[IW-1:0]][k*8 +: 8];
`endif
    if (commit && win) begin
      regs_d[widx[IW-1:0]]   = wdata_m;
      reg_wr_d[widx[IW-1:0]] = 1'b1;
    end
    // Flags only clear on commit, and READY is low whenever a flag is set,
    // so capture and commit can never collide on the same edge.
    aw_full_d = commit ? 1'b0 : aw_full_q | AWVALID;
    w_full_d  = commit ? 1'b0 : w_full_q | WVALID;
    aw_addr_d = (!aw_full_q && AWVALID) ? AWADDR : aw_addr_q;
    w_data_d  = (!w_full_q && WVALID) ? WDATA : w_data_q;
    w_strb_d  = (!w_full_q && WVALID) ? WSTRB : w_strb_q;
    bvalid_d  = commit ? 1'b1 : bvalid_q && !BREADY;
    bresp_d   = commit ? (win ? 2'b00 : 2'b10) : bresp_q;
    rvalid_d  = ar_hs ? 1'b1 : rvalid_q && !RREADY;
    rresp_d   = ar_hs ? (rin ? 2'b00 : 2'b10) : rresp_q;
    rdata_d   = ar_hs ? (rin ? regs_q[ridx[IW-1:0]] : '0) : rdata_q;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      regs_q    <= '{default: '0};
      reg_wr_q  <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      reg_wr_q  <= reg_wr_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi4l_regfile.sv
// tb_axi4l_regfile: self-checking bench for axi4l_regfile against an array-based register model
module tb_axi4l_regfile;
  localparam int AW = 12, DW = 32, NR = 8;
  logic clk = 0;
  always #5 clk = ~clk;
  logic ARESETN, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0] reg_wr;
  logic [DW-1:0] model [NR];
  int cmp = 0, errs = 0;
  axi4l_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = nw;
`ifdef AXI4L_REGFILE_STRB_EN
    for (int k = 0; k < 4; k++) if (!s[k]) r[k*8 +: 8] = old[k*8 +: 8];
`endif
    return r;
  endfunction
  function automatic logic [31:0] rq(input int i);
    return reg_q[i*DW +: DW];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int pulses, output logic [NR-1:0] mask);
    logic aw_r, w_r, done;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    pulses = 0; mask = '0; resp = 2'b11; done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      aw_r = AWVALID && AWREADY;
      w_r  = WVALID && WREADY;
      tick;
      if (aw_r) AWVALID = 0;
      if (w_r) WVALID = 0;
      if (reg_wr != 0) begin pulses++; mask |= reg_wr; end
      if (BVALID) begin resp = BRESP; done = 1; end
    end
    cmp++;
    if (!done) begin errs++; $display("FAIL write_timeout: got BVALID=0 exp BVALID=1 addr=%h", a); end
    AWVALID = 0; WVALID = 0;
    tick;
    if (reg_wr != 0) pulses++;
  endtask
  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic r;
    ARADDR = a; ARVALID = 1; RREADY = 1; r = 0;
    for (int n = 0; n < 20 && !r; n++) begin
      r = ARREADY;
      tick;
    end
    ARVALID = 0;
    cmp++;
    if (!RVALID) begin errs++; $display("FAIL read_timeout: got RVALID=0 exp RVALID=1 addr=%h", a); end
    d = RDATA; resp = RRESP;
    tick;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    logic [1:0] r;
    ARESETN = 0;
    tick; tick;
    ARESETN = 1;
    cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      errs++; $display("FAIL reset_hs: got %b exp 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    cmp++;
    if ({BRESP, RRESP, RDATA, reg_wr} !== '0) begin
      errs++; $display("FAIL reset_out: got bresp=%h rresp=%h rdata=%h reg_wr=%h exp 0", BRESP, RRESP, RDATA, reg_wr);
    end
    for (int i = 0; i < NR; i++) begin
      model[i] = '0;
      do_read(AW'(i*4), d, r);
      cmp++;
      if (d !== 32'h0 || r !== 2'b00) begin errs++; $display("FAIL reset_read%0d: got %h/%b exp 0/00", i, d, r); end
    end
  endtask
  task automatic test_write_same_cycle;
    logic [31:0] d;
    logic [1:0] r;
    AWADDR = 12'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    cmp++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin errs++; $display("FAIL same_capture: got %b exp 000", {AWREADY, WREADY, BVALID}); end
    tick;
    cmp++;
    if (BVALID !== 1 || BRESP !== 2'b00 || reg_wr !== 8'h02 || rq(1) !== 32'hDEADBEEF) begin
      errs++; $display("FAIL same_commit: got bv=%b br=%b wr=%h r1=%h exp 1/00/02/deadbeef", BVALID, BRESP, reg_wr, rq(1));
    end
    model[1] = 32'hDEADBEEF;
    tick;
    cmp++;
    if (BVALID !== 0 || reg_wr !== 8'h00) begin errs++; $display("FAIL same_release: got bv=%b wr=%h exp 0/00", BVALID, reg_wr); end
    do_read(12'h4, d, r);
    cmp++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin errs++; $display("FAIL same_readback: got %h/%b exp deadbeef/00", d, r); end
  endtask
  task automatic test_w_before_aw;
    logic [31:0] d;
    logic [1:0] r;
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1; AWVALID = 0; BREADY = 1;
    tick;
    WVALID = 0;
    cmp++;
    if (WREADY !== 0 || AWREADY !== 1) begin errs++; $display("FAIL wfirst_ready: got w=%b aw=%b exp 0/1", WREADY, AWREADY); end
    tick; tick;
    cmp++;
    if (BVALID !== 0 || rq(2) !== model[2] || reg_wr !== 0) begin
      errs++; $display("FAIL wfirst_stall: got bv=%b r2=%h wr=%h exp 0/%h/00", BVALID, rq(2), reg_wr, model[2]);
    end
    AWADDR = 12'h8; AWVALID = 1;
    tick;
    AWVALID = 0;
    tick;
    cmp++;
    if (BVALID !== 1 || BRESP !== 2'b00 || reg_wr !== 8'h04 || rq(2) !== 32'h12345678) begin
      errs++; $display("FAIL wfirst_commit: got bv=%b br=%b wr=%h r2=%h exp 1/00/04/12345678", BVALID, BRESP, reg_wr, rq(2));
    end
    model[2] = 32'h12345678;
    tick;
    do_read(12'h8, d, r);
    cmp++;
    if (d !== 32'h12345678 || r !== 2'b00) begin errs++; $display("FAIL wfirst_readback: got %h/%b exp 12345678/00", d, r); end
  endtask
  task automatic test_strobe;
    logic [31:0] d, e;
    logic [1:0] r;
    int p;
    logic [NR-1:0] m;
    do_write(12'h8, 32'h12345678, 4'hF, r, p, m);
    do_write(12'h8, 32'hAABBCCDD, 4'b0101, r, p, m);
`ifdef AXI4L_REGFILE_STRB_EN
    e = 32'h12BB56DD;
`else
    e = 32'hAABBCCDD;
`endif
    do_read(12'h8, d, r);
    cmp++;
    if (d !== e) begin errs++; $display("FAIL strb_partial: got %h exp %h", d, e); end
    do_write(12'h8, 32'h11111111, 4'h0, r, p, m);
`ifndef AXI4L_REGFILE_STRB_EN
    e = 32'h11111111;
`endif
    cmp++;
    if (r !== 2'b00 || p !== 1 || m !== 8'h04) begin errs++; $display("FAIL strb_zero_resp: got %b/%0d/%h exp 00/1/04", r, p, m); end
    do_read(12'h8, d, r);
    cmp++;
    if (d !== e) begin errs++; $display("FAIL strb_zero_data: got %h exp %h", d, e); end
    model[2] = e;
  endtask
  task automatic test_out_of_range;
    logic [31:0] d;
    logic [1:0] r;
    int p;
    logic [NR-1:0] m;
    logic [AW-1:0] bad [2];
    bad[0] = AW'(NR*4);
    bad[1] = 12'h400;
    for (int j = 0; j < 2; j++) begin
      do_write(bad[j], 32'hCAFEF00D, 4'hF, r, p, m);
      cmp++;
      if (r !== 2'b10 || p !== 0) begin errs++; $display("FAIL oor_write%0d: got %b/%0d exp 10/0", j, r, p); end
      do_read(bad[j], d, r);
      cmp++;
      if (d !== 0 || r !== 2'b10) begin errs++; $display("FAIL oor_read%0d: got %h/%b exp 0/10", j, d, r); end
    end
    for (int i = 0; i < NR; i++) begin
      cmp++;
      if (rq(i) !== model[i]) begin errs++; $display("FAIL oor_regs%0d: got %h exp %h", i, rq(i), model[i]); end
    end
  endtask
  task automatic test_random;
    logic [AW-1:0] a;
    logic [31:0] d, wd;
    logic [3:0] s;
    logic [1:0] r;
    int p, idx;
    logic [NR-1:0] m;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR*4 + 15));
      idx = int'(a) / 4;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, wd, s, r, p, m);
        cmp++;
        if (idx < NR) begin
          if (r !== 2'b00 || p !== 1 || m !== NR'(1 << idx)) begin
            errs++; $display("FAIL rnd_write a=%h: got %b/%0d/%h exp 00/1/%h", a, r, p, m, NR'(1 << idx));
          end
          model[idx] = merge(model[idx], wd, s);
        end else if (r !== 2'b10 || p !== 0) begin
          errs++; $display("FAIL rnd_write a=%h: got %b/%0d exp 10/0", a, r, p);
        end
      end else begin
        do_read(a, d, r);
        cmp++;
        if (d !== (idx < NR ? model[idx] : 32'h0) || r !== (idx < NR ? 2'b00 : 2'b10)) begin
          errs++; $display("FAIL rnd_read a=%h: got %h/%b exp %h/%b", a, d, r, idx < NR ? model[idx] : 32'h0, idx < NR ? 2'b00 : 2'b10);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      cmp++;
      if (rq(i) !== model[i]) begin errs++; $display("FAIL rnd_regs%0d: got %h exp %h", i, rq(i), model[i]); end
    end
  endtask
  task automatic test_backpressure_reset;
    logic [31:0] da, db, dc;
    da = $urandom; db = $urandom; dc = $urandom;
    BREADY = 0; AWADDR = 12'h0; WDATA = da; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    tick;
    AWADDR = 12'h4; WDATA = db;
    tick;
    model[0] = da;
    cmp++;
    if (BVALID !== 1 || rq(0) !== da) begin errs++; $display("FAIL bp_first: got bv=%b r0=%h exp 1/%h", BVALID, rq(0), da); end
    tick;
    AWVALID = 0; WVALID = 0;
    for (int n = 0; n < 5; n++) begin
      cmp++;
      if (BVALID !== 1 || rq(1) !== model[1] || reg_wr !== 0) begin
        errs++; $display("FAIL bp_hold%0d: got bv=%b r1=%h wr=%h exp 1/%h/00", n, BVALID, rq(1), reg_wr, model[1]);
      end
      tick;
    end
    BREADY = 1;
    tick;
    BREADY = 0;
    cmp++;
    if (BVALID !== 0) begin errs++; $display("FAIL bp_consume: got bv=%b exp 0", BVALID); end
    tick;
    model[1] = db;
    cmp++;
    if (BVALID !== 1 || reg_wr !== 8'h02 || rq(1) !== db) begin
      errs++; $display("FAIL bp_second: got bv=%b wr=%h r1=%h exp 1/02/%h", BVALID, reg_wr, rq(1), db);
    end
    AWADDR = 12'h8; WDATA = dc; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick; tick;
    cmp++;
    if (BVALID !== 1 || rq(2) !== model[2]) begin errs++; $display("FAIL bp_third_stall: got bv=%b r2=%h exp 1/%h", BVALID, rq(2), model[2]); end
    ARESETN = 0;
    tick;
    ARESETN = 1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    cmp++;
    if (BVALID !== 0 || reg_q !== '0 || AWREADY !== 1 || WREADY !== 1) begin
      errs++; $display("FAIL bp_reset: got bv=%b regs=%h aw=%b w=%b exp 0/0/1/1", BVALID, reg_q, AWREADY, WREADY);
    end
    BREADY = 1;
    tick; tick;
    cmp++;
    if (BVALID !== 0 || reg_wr !== 0 || reg_q !== '0) begin
      errs++; $display("FAIL bp_no_commit: got bv=%b wr=%h regs=%h exp 0/00/0", BVALID, reg_wr, reg_q);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ARESETN = 0; AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    test_reset;
    test_write_same_cycle;
    test_w_before_aw;
    test_strobe;
    test_out_of_range;
    test_random;
    test_backpressure_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
